// File: rtl/lab3_ram_pkg.sv
// Shared definitions for the pipelined on-chip RAM.
//   ram_state_t      : controller state (zero-fill or idle/serving requests)
//   READ_LATENCY_MIN : shortest supported read latency (registered array read)
//   READ_LATENCY_MAX : longest supported read latency (adds an output register)
//   be_w()           : number of byte lanes for a given data width
package lab3_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_be.sv
// Byte-enabled single-port RAM, DEPTH x DATA_W, with a one-cycle registered
// read and a clock enable. Written so it maps onto block RAM.
// Read-before-write within one cycle; a write is visible to a read on the
// following edge.
//   clk   : clock
//   en    : clock enable, 0 freezes the array and the read register
//   we    : write enable
//   be    : byte-lane enables for the write
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (contents of addr at the previous edge)
module ram_sp_be
  import lab3_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 25000,
  parameter int AW     = 15
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [be_w(DATA_W)-1:0]  be,
  input  logic [AW-1:0]            addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BE_W = be_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lab3_qsys_onchip_ram_pipelined.sv
// Parametrised single-port on-chip RAM with an Avalon-MM slave interface.
// Owns the zero-fill controller, request arbitration, address range check and
// the read-latency pipeline; storage lives in ram_sp_be.
//   clk, reset     : clock, synchronous active-high reset
//   address        : word address
//   byteenable     : write byte lanes
//   chipselect     : slave select
//   read, write    : requests (both set together = write only)
//   writedata      : write data
//   clken          : clock enable, 0 freezes the whole block
//   readdata       : read data, meaningful while readdatavalid=1, else held
//   readdatavalid  : one-cycle read-data strobe, READ_LATENCY after accept
//   waitrequest    : request not accepted this cycle
//   busy           : zero-fill in progress
module lab3_qsys_onchip_ram_pipelined
  import lab3_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int DEPTH          = 25000,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  input  logic                     clken,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  output logic                     waitrequest,
  output logic                     busy
);

  localparam int BE_W = be_w(DATA_W);
  // Array address width only needs to cover DEPTH; out-of-range addresses
  // never reach the array as writes and their read data is masked.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH - 1);
  localparam ram_state_t      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  ram_state_t        state_q, state_d;
  logic [AW-1:0]     clr_cnt, clr_cnt_d;
  logic              in_range, accept, rd_accept;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              vld_p0, oor_p0;
  logic [DATA_W-1:0] word_p0;

  assign busy        = (state_q == ST_CLEAR);
  assign waitrequest = busy || !clken;
  assign in_range    = ({1'b0, address} < DEPTH_V);
  assign accept      = !waitrequest && chipselect && (read || write);
  // A combined read+write is treated as a write; the read is dropped.
  assign rd_accept   = accept && read && !write;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt;
    if (clken && state_q == ST_CLEAR) begin
      if (clr_cnt == LAST_WORD) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // The fill engine owns the array port while busy; writes are suppressed on
  // the reset edge so a restart never leaves a stray write behind.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = byteenable;
    ram_addr  = address[AW-1:0];
    ram_wdata = writedata;
    if (busy) begin
      ram_we    = !reset;
      ram_be    = '1;
      ram_addr  = clr_cnt;
      ram_wdata = '0;
    end else begin
      ram_we = !reset && accept && write && in_range;
    end
  end

  ram_sp_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .en    (clken),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // ---- stage p0: array read register output, one cycle after accept ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      oor_p0 <= 1'b0;
    end else if (clken) begin
      vld_p0 <= rd_accept;
      oor_p0 <= !in_range;
    end
  end

  assign word_p0 = oor_p0 ? '0 : ram_q;

  // ---- stage p1: either a hold register (latency 1) or output register ----
  generate
    if (READ_LATENCY <= READ_LATENCY_MIN) begin : g_lat1
      logic [DATA_W-1:0] hold_p1;

      // The array output changes every enabled cycle, so the last delivered
      // word is kept to hold readdata while readdatavalid is low.
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_p1 <= '0;
        end else if (clken && vld_p0) begin
          hold_p1 <= word_p0;
        end
      end

      assign readdatavalid = vld_p0;
      assign readdata      = vld_p0 ? word_p0 : hold_p1;
    end else begin : g_lat2
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else if (clken) begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= word_p0;
        end
      end

      assign readdatavalid = vld_p1;
      assign readdata      = data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_lab3_qsys_onchip_ram_pipelined.sv
module tb_lab3_qsys_onchip_ram_pipelined;

  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        reset, chipselect, read, write, clken;
  logic [4:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rdata1, rdata2;
  logic        rvld1, rvld2, wreq1, wreq2, busy1, busy2;

  always #5 clk = ~clk;

  lab3_qsys_onchip_ram_pipelined #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DEP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata1), .readdatavalid(rvld1),
    .waitrequest(wreq1), .busy(busy1)
  );

  lab3_qsys_onchip_ram_pipelined #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DEP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata2), .readdatavalid(rvld2),
    .waitrequest(wreq2), .busy(busy2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: word array, remaining fill cycles, and per-latency
  // queues of outstanding reads with the enabled edges left until delivery.
  logic [31:0] mem_m [DEP];
  int          fill_left = 0;
  bit          model_on = 0;
  typedef struct { logic [31:0] d; int rem; } rd_t;
  rd_t q1[$];
  rd_t q2[$];

  typedef struct {
    bit cs; bit rd; bit wr; logic [4:0] a; logic [3:0] be; logic [31:0] wd;
    bit v1; logic [31:0] d1; bit v2; logic [31:0] d2;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit e1, e2;
    e1 = (q1.size() > 0) && (q1[0].rem == 1);
    e2 = (q2.size() > 0) && (q2[0].rem == 1);
    chk("busy_l1", busy1, fill_left > 0);
    chk("busy_l2", busy2, fill_left > 0);
    chk("waitreq_l1", wreq1, (fill_left > 0) || !clken);
    chk("waitreq_l2", wreq2, (fill_left > 0) || !clken);
    chk("rdvld_l1", rvld1, e1);
    chk("rdvld_l2", rvld2, e2);
    if (e1) chk("rdata_l1", rdata1, q1[0].d);
    if (e2) chk("rdata_l2", rdata2, q2[0].d);
  endtask

  task automatic step();
    bit acc, w;
    logic [4:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    rd_t r;
    acc = !reset && clken && (fill_left == 0) && chipselect && (read || write);
    a = address; be = byteenable; wd = writedata; w = write;
    @(posedge clk);
    if (reset) begin
      q1.delete(); q2.delete();
      fill_left = DEP;
    end else if (clken) begin
      foreach (q1[i]) q1[i].rem--;
      while (q1.size() > 0 && q1[0].rem <= 0) void'(q1.pop_front());
      foreach (q2[i]) q2[i].rem--;
      while (q2.size() > 0 && q2[0].rem <= 0) void'(q2.pop_front());
      if (fill_left > 0) begin
        fill_left--;
        if (fill_left == 0) foreach (mem_m[i]) mem_m[i] = '0;
      end
      if (acc) begin
        if (w) begin
          if (a < DEP)
            for (int i = 0; i < 4; i++) if (be[i]) mem_m[a][8*i +: 8] = wd[8*i +: 8];
        end else begin
          r.d = (a < DEP) ? mem_m[a] : 32'h0;
          r.rem = 1; q1.push_back(r);
          r.rem = 2; q2.push_back(r);
        end
      end
    end
    #1;
    if (model_on) check_model();
  endtask

  task automatic drive(input bit cs, input bit rd, input bit wr, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 5'd0, 4'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset for one edge, then count cycles with busy=1 (including the cycle
  // right after the reset edge) until the fill completes.
  task automatic reset_and_count(input string name);
    int cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = busy2 ? 1 : 0;
    while (busy2 && cnt < 100) begin
      step();
      if (busy2) cnt++;
    end
    chk(name, cnt, DEP);
  endtask

  initial begin
    int n;
    tbl[0]  = '{1, 0, 1, 5'd5, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0};
    tbl[1]  = '{1, 0, 1, 5'd5, 4'h5, 32'h11223344, 0, 32'h0, 0, 32'h0};
    tbl[2]  = '{1, 0, 1, 5'd0, 4'hF, 32'h000000A0, 0, 32'h0, 0, 32'h0};
    tbl[3]  = '{1, 0, 1, 5'd1, 4'hF, 32'h000000A1, 0, 32'h0, 0, 32'h0};
    tbl[4]  = '{1, 0, 1, 5'd2, 4'hF, 32'h000000A2, 0, 32'h0, 0, 32'h0};
    tbl[5]  = '{1, 0, 1, 5'd3, 4'hF, 32'h000000A3, 0, 32'h0, 0, 32'h0};
    tbl[6]  = '{1, 1, 0, 5'd5, 4'h0, 32'h0, 1, 32'hDE22BE44, 0, 32'h0};
    tbl[7]  = '{1, 1, 0, 5'd0, 4'h0, 32'h0, 1, 32'h000000A0, 1, 32'hDE22BE44};
    tbl[8]  = '{1, 1, 0, 5'd1, 4'h0, 32'h0, 1, 32'h000000A1, 1, 32'h000000A0};
    tbl[9]  = '{1, 1, 0, 5'd2, 4'h0, 32'h0, 1, 32'h000000A2, 1, 32'h000000A1};
    tbl[10] = '{1, 1, 0, 5'd3, 4'h0, 32'h0, 1, 32'h000000A3, 1, 32'h000000A2};
    tbl[11] = '{0, 0, 0, 5'd0, 4'h0, 32'h0, 0, 32'h0, 1, 32'h000000A3};
    tbl[12] = '{0, 0, 0, 5'd0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0};

    reset = 1'b1; clken = 1'b1;
    drive(0, 0, 0, 5'd0, 4'h0, 32'h0);
    step();
    step();
    model_on = 1;
    chk("reset_rdvld_l1", rvld1, 0);
    chk("reset_rdvld_l2", rvld2, 0);
    chk("reset_rdata_l1", rdata1, 0);
    chk("reset_rdata_l2", rdata2, 0);

    // Zero-fill duration, then every word reads back as zero.
    reset_and_count("fill_cycles");
    for (int a = 0; a < DEP; a++) begin
      drive(1, 1, 0, 5'(a), 4'h0, 32'h0);
      step();
    end
    idle(3);

    // Byte-lane writes and back-to-back reads from the vector table.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd);
      step();
      chk($sformatf("tbl%0d_rdvld_l1", i), rvld1, tbl[i].v1);
      chk($sformatf("tbl%0d_rdvld_l2", i), rvld2, tbl[i].v2);
      if (tbl[i].v1) chk($sformatf("tbl%0d_rdata_l1", i), rdata1, tbl[i].d1);
      if (tbl[i].v2) chk($sformatf("tbl%0d_rdata_l2", i), rdata2, tbl[i].d2);
    end

    // Clock-enable freeze with a read in flight.
    drive(1, 1, 0, 5'd1, 4'h0, 32'h0);
    step();
    drive(0, 0, 0, 5'd0, 4'h0, 32'h0);
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_waitreq", wreq2, 1);
      chk("freeze_rdvld_l1", rvld1, 1);
      chk("freeze_rdata_l1", rdata1, 32'hA1);
    end
    clken = 1'b1;
    n = 3;
    do begin
      step();
      n++;
    end while (!rvld2 && n < 12);
    chk("clken_delay", n, 4);
    chk("clken_rdata_l2", rdata2, 32'hA1);
    idle(2);

    // Out-of-range accesses and combined read+write.
    drive(1, 0, 1, 5'd20, 4'hF, 32'h55AA55AA);
    step();
    drive(1, 1, 0, 5'd20, 4'h0, 32'h0);
    step();
    chk("oor_rdvld", rvld1, 1);
    chk("oor_rdata", rdata1, 0);
    drive(1, 1, 0, 5'd4, 4'h0, 32'h0);
    step();
    chk("alias_rdata", rdata1, 0);
    drive(1, 1, 1, 5'd3, 4'hF, 32'h12345678);
    step();
    chk("rw_no_rdvld_l1", rvld1, 0);
    drive(0, 0, 0, 5'd0, 4'h0, 32'h0);
    step();
    chk("rw_no_rdvld_l2", rvld2, 0);
    drive(1, 1, 0, 5'd3, 4'h0, 32'h0);
    step();
    chk("rw_write_applied", rdata1, 32'h12345678);
    idle(3);

    // Reset with a read in flight, then reset again part-way through the fill.
    drive(1, 1, 0, 5'd2, 4'h0, 32'h0);
    step();
    drive(0, 0, 0, 5'd0, 4'h0, 32'h0);
    reset = 1'b1;
    step();
    chk("flush_rdvld_l1", rvld1, 0);
    reset = 1'b0;
    step();
    chk("flush_rdvld_l2", rvld2, 0);
    for (int i = 0; i < 6; i++) step();
    reset_and_count("refill_cycles");

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      clken = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 19)), 4'($urandom_range(0, 15)), $urandom);
      step();
    end
    reset = 1'b0; clken = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
